// File: rtl/debounce_event.sv
// Multi-channel switch conditioner: 2-flop synchroniser, tick-rate shift-register
// debounce, and registered rise/fall/long-press event pulses per channel.
module debounce_event #(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      N          = 4,
  parameter int unsigned      RATE       = 125000,
  parameter int unsigned      HOLD_TICKS = 250,
  parameter logic [WIDTH-1:0] INIT       = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] hold
);

  localparam int unsigned CNT_W = (RATE > 1) ? $clog2(RATE) : 1;

  logic [WIDTH-1:0] s1_q, s2_q;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_c;

  logic [WIDTH-1:0][N-1:0] shreg_q, shreg_d;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  // Synchroniser for the asynchronous switch inputs; deliberately not reset.
  always_ff @(posedge clk) begin
    s1_q <= in;
    s2_q <= s1_q;
  end

  always_comb begin
    tick_c = (cnt_q == CNT_W'(RATE - 1));
    cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
  end

  always_comb begin
    shreg_d = shreg_q;
    if (tick_c) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        shreg_d[i] = {shreg_q[i][N-2:0], s2_q[i]};
      end
    end
  end

  // Level only changes on a unanimous window; mixed windows keep the old level.
  always_comb begin
    out_d = out_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (&shreg_q[i]) begin
        out_d[i] = 1'b1;
      end else if (~|shreg_q[i]) begin
        out_d[i] = 1'b0;
      end
    end
    rise_d = out_d & ~out_q;
    fall_d = ~out_d & out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      out_q  <= INIT;
      rise_q <= '0;
      fall_q <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        shreg_q[i] <= {N{INIT[i]}};
      end
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

  generate
    if (HOLD_TICKS > 0) begin : g_hold
      localparam int unsigned HC_W = $clog2(HOLD_TICKS + 1);

      logic [WIDTH-1:0][HC_W-1:0] hcnt_q, hcnt_d;
      logic [WIDTH-1:0]           hold_q, hold_d;

      // Counter saturates at HOLD_TICKS so each press yields a single pulse.
      always_comb begin
        hcnt_d = hcnt_q;
        hold_d = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if (!out_q[i]) begin
            hcnt_d[i] = '0;
          end else if (tick_c && (hcnt_q[i] < HC_W'(HOLD_TICKS))) begin
            hcnt_d[i] = hcnt_q[i] + HC_W'(1);
            hold_d[i] = (hcnt_q[i] == HC_W'(HOLD_TICKS - 1));
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          hcnt_q <= '0;
          hold_q <= '0;
        end else begin
          hcnt_q <= hcnt_d;
          hold_q <= hold_d;
        end
      end

      assign hold = hold_q;
    end else begin : g_no_hold
      assign hold = '0;
    end
  endgenerate

endmodule

// File: tb/tb_debounce_event.sv
// Bench for debounce_event: two instances (INIT 00 and 10) checked every cycle
// against a run-length behavioural model, plus hand-computed event timings.
module tb_debounce_event;

  localparam int unsigned W  = 2;
  localparam int unsigned NN = 4;
  localparam int unsigned RT = 4;
  localparam int unsigned HT = 3;
  localparam logic [W-1:0] INIT_A = 2'b00;
  localparam logic [W-1:0] INIT_B = 2'b10;

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] in_a, in_b;
  logic [W-1:0] out_a, rise_a, fall_a, hold_a;
  logic [W-1:0] out_b, rise_b, fall_b, hold_b;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  debounce_event #(.WIDTH(W), .N(NN), .RATE(RT), .HOLD_TICKS(HT), .INIT(INIT_A)) dut_a (
    .clk(clk), .rst(rst), .in(in_a), .out(out_a), .rise(rise_a), .fall(fall_a), .hold(hold_a)
  );

  debounce_event #(.WIDTH(W), .N(NN), .RATE(RT), .HOLD_TICKS(HT), .INIT(INIT_B)) dut_b (
    .clk(clk), .rst(rst), .in(in_b), .out(out_b), .rise(rise_b), .fall(fall_b), .hold(hold_b)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each channel tracks the value and length of the current run of equal
  // tick samples; the level follows once a run reaches N, and hold fires on the
  // HT-th tick seen while the level is 1.
  logic [W-1:0] m_out [2], m_rise [2], m_fall [2], m_hold [2];
  logic [W-1:0] m_s1 [2], m_s2 [2];
  logic         run_val [2][W];
  int           run_len [2][W];
  int           hticks  [2][W];
  int           m_e = 0;

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_s1[d] = '0;
      m_s2[d] = '0;
    end
  end

  always @(posedge clk) begin
    logic [W-1:0] inx, init;
    logic         tk, nxt;
    for (int d = 0; d < 2; d++) begin
      inx  = (d == 0) ? in_a : in_b;
      init = (d == 0) ? INIT_A : INIT_B;
      if (rst) begin
        m_out[d]  = init;
        m_rise[d] = '0;
        m_fall[d] = '0;
        m_hold[d] = '0;
        for (int c = 0; c < int'(W); c++) begin
          run_val[d][c] = init[c];
          run_len[d][c] = NN;
          hticks[d][c]  = 0;
        end
      end else begin
        tk = ((m_e + 1) % RT) == 0;
        for (int c = 0; c < int'(W); c++) begin
          nxt = (run_len[d][c] >= int'(NN)) ? run_val[d][c] : m_out[d][c];
          m_rise[d][c] = nxt & ~m_out[d][c];
          m_fall[d][c] = ~nxt & m_out[d][c];
          m_hold[d][c] = 1'b0;
          if (!m_out[d][c]) begin
            hticks[d][c] = 0;
          end else if (tk && hticks[d][c] < int'(HT)) begin
            hticks[d][c]++;
            m_hold[d][c] = (hticks[d][c] == int'(HT));
          end
          if (tk) begin
            if (m_s2[d][c] == run_val[d][c]) begin
              if (run_len[d][c] < int'(NN)) run_len[d][c]++;
            end else begin
              run_val[d][c] = m_s2[d][c];
              run_len[d][c] = 1;
            end
          end
          m_out[d][c] = nxt;
        end
      end
      m_s2[d] = m_s1[d];
      m_s1[d] = inx;
    end
    m_e = rst ? 0 : m_e + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_out",  int'(out_a),  int'(m_out[0]));
      check("a_rise", int'(rise_a), int'(m_rise[0]));
      check("a_fall", int'(fall_a), int'(m_fall[0]));
      check("a_hold", int'(hold_a), int'(m_hold[0]));
      check("b_out",  int'(out_b),  int'(m_out[1]));
      check("b_rise", int'(rise_b), int'(m_rise[1]));
      check("b_fall", int'(fall_b), int'(m_fall[1]));
      check("b_hold", int'(hold_b), int'(m_hold[1]));
    end
  end

  initial begin
    int rise_at, hold_at, b_at, nr, nf, nh, no;
    bit found;
    rst  = 1'b1;
    in_a = '0;
    in_b = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_out_a", int'(out_a), 0);
    check("reset_out_b", int'(out_b), 2);
    check("reset_pulses_a", int'({rise_a, fall_a, hold_a}), 0);
    check("reset_pulses_b", int'({rise_b, fall_b, hold_b}), 0);

    // Clean press / long press on A, simultaneous opposite edges on B.
    rst = 1'b0; in_a = 2'b01; in_b = 2'b01;
    rise_at = -1; hold_at = -1; b_at = -1; nr = 0; nf = 0; nh = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (rise_a[0]) begin
        nr++;
        if (rise_at < 0) begin
          rise_at = c;
          check("press_out_with_rise", int'(out_a[0]), 1);
        end
      end
      if (fall_a[0]) nf++;
      if (hold_a[0]) begin
        nh++;
        if (hold_at < 0) hold_at = c;
      end
      if (rise_b[0] && b_at < 0) begin
        b_at = c;
        check("simul_fall1", int'(fall_b[1]), 1);
        check("simul_out_b", int'(out_b), 1);
      end
    end
    check("press_rise_cycle", rise_at, 17);
    check("press_rise_count", nr, 1);
    check("press_fall_count", nf, 0);
    check("hold_cycle", hold_at, 28);
    check("hold_count", nh, 1);
    check("simul_cycle", b_at, 17);

    // Release.
    in_a = 2'b00; nf = 0; nr = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (fall_a[0]) nf++;
      if (rise_a[0]) nr++;
    end
    check("release_fall_count", nf, 1);
    check("release_rise_count", nr, 0);
    check("release_out", int'(out_a[0]), 0);

    // Glitch: 8 cycles high covers at most 2 ticks.
    in_a = 2'b01; nr = 0; nf = 0; no = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 8) in_a = 2'b00;
      if (rise_a[0]) nr++;
      if (fall_a[0]) nf++;
      if (out_a[0]) no++;
    end
    check("glitch_rise", nr, 0);
    check("glitch_fall", nf, 0);
    check("glitch_out_high_cycles", no, 0);

    // Re-press: hold fires again.
    in_a = 2'b01; nr = 0; nh = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (rise_a[0]) nr++;
      if (hold_a[0]) nh++;
    end
    check("repress_rise_count", nr, 1);
    check("repress_hold_count", nh, 1);

    // Reset in the cycle rise[0] is high.
    in_a = 2'b00;
    repeat (30) @(negedge clk);
    in_a = 2'b01;
    found = 1'b0;
    for (int c = 1; c <= 30 && !found; c++) begin
      @(negedge clk);
      if (rise_a[0]) found = 1'b1;
    end
    check("midreset_rise_seen", int'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_out", int'(out_a), 0);
    check("midreset_pulses", int'({rise_a, fall_a, hold_a}), 0);
    rst = 1'b0;
    nf = 0; rise_at = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (fall_a[0]) nf++;
      if (rise_a[0] && rise_at < 0) rise_at = c;
    end
    check("midreset_no_fall", nf, 0);
    check("midreset_rerise_cycle", rise_at, 17);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
